// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: synchronise and filter the pins, deframe 11-bit frames, fold E0/F0 prefixes into flags.
// Optional PS2_BREAK_FILTER_EN: break codes are swallowed and clear scanCode when they release the held key.
module ps2_scancode_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scanCode,
    output logic       detected,
    output logic       extended,
    output logic       released,
    output logic       frame_err
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_sync_q;
    logic [1:0]    dat_sync_q;
    logic          filt_q;
    logic [FW-1:0] fcnt_q;
    logic          fall_q;
    state_t        state_q;
    logic [2:0]    bitcnt_q;
    logic [7:0]    shift_q;
    logic          parity_q;
    logic [TW-1:0] tcnt_q;
    logic          ext_q;
    logic          brk_q;
    logic [7:0]    scan_q;
    logic          det_q;
    logic          ext_out_q;
    logic          rel_out_q;
    logic          err_q;
    logic          dat;

    assign dat       = dat_sync_q[1];
    assign scanCode  = scan_q;
    assign detected  = det_q;
    assign extended  = ext_out_q;
    assign released  = rel_out_q;
    assign frame_err = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_data};
        end
    end

    // Level only flips after FILTER_LEN consecutive disagreeing cycles; fall_q marks a 1->0 flip.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= 1'b1;
            fcnt_q <= '0;
            fall_q <= 1'b0;
        end else if (clk_sync_q[1] == filt_q) begin
            fcnt_q <= '0;
            fall_q <= 1'b0;
        end else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
            filt_q <= ~filt_q;
            fcnt_q <= '0;
            fall_q <= filt_q;
        end else begin
            fcnt_q <= fcnt_q + 1'b1;
            fall_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bitcnt_q  <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tcnt_q    <= '0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            scan_q    <= '0;
            det_q     <= 1'b0;
            ext_out_q <= 1'b0;
            rel_out_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            det_q <= 1'b0;
            err_q <= 1'b0;
            if (state_q == IDLE) begin
                tcnt_q <= '0;
                if (fall_q && !dat) begin
                    state_q  <= DATA;
                    bitcnt_q <= '0;
                end
            end else if (fall_q) begin
                tcnt_q <= '0;
                case (state_q)
                    DATA: begin
                        shift_q  <= {dat, shift_q[7:1]};
                        bitcnt_q <= bitcnt_q + 1'b1;
                        if (bitcnt_q == 3'd7) state_q <= PARITY;
                    end
                    PARITY: begin
                        parity_q <= dat;
                        state_q  <= STOP;
                    end
                    default: begin
                        state_q <= IDLE;
                        if (dat && (^{shift_q, parity_q})) begin
                            if (shift_q == 8'hE0) begin
                                ext_q <= 1'b1;
                            end else if (shift_q == 8'hF0) begin
                                brk_q <= 1'b1;
                            end else begin
`ifdef PS2_BREAK_FILTER_EN
                                if (brk_q) begin
                                    if (shift_q == scan_q) scan_q <= 8'h00;
                                end else begin
                                    scan_q    <= shift_q;
                                    ext_out_q <= ext_q;
                                    rel_out_q <= 1'b0;
                                    det_q     <= 1'b1;
                                end
`else
                                scan_q    <= shift_q;
                                ext_out_q <= ext_q;
                                rel_out_q <= brk_q;
                                det_q     <= 1'b1;
`endif
                                ext_q <= 1'b0;
                                brk_q <= 1'b0;
                            end
                        end else begin
                            err_q <= 1'b1;
                            ext_q <= 1'b0;
                            brk_q <= 1'b0;
                        end
                    end
                endcase
            end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_q <= IDLE;
                tcnt_q  <= '0;
                err_q   <= 1'b1;
                ext_q   <= 1'b0;
                brk_q   <= 1'b0;
            end else begin
                tcnt_q <= tcnt_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Randomised PS/2 frame bench; a transaction-level event queue predicts every detected/frame_err pulse.
`timescale 1ns/1ps
module tb_ps2_scancode_rx;
    localparam int FL   = 8;
    localparam int TO   = 600;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] scanCode;
    logic       detected, extended, released, frame_err;

    ps2_scancode_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .scanCode(scanCode), .detected(detected), .extended(extended),
        .released(released), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         err;
        logic [7:0] code;
        bit         ext;
        bit         rel;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        ev;
    int         total = 0;
    int         bad = 0;
    bit         m_ext = 0;
    bit         m_brk = 0;
    logic [7:0] m_scan = 8'h00;

    // Reference: what a complete frame must produce, from the protocol rules alone.
    function automatic void model_frame(logic [7:0] b, bit ok);
        ev_t e;
        e.err = 0; e.code = b; e.ext = m_ext; e.rel = 0;
        if (!ok) begin
            e.err = 1; e.code = 8'h00; e.ext = 0;
            exp_q.push_back(e);
            m_ext = 0; m_brk = 0;
            return;
        end
        if (b == 8'hE0) begin m_ext = 1; return; end
        if (b == 8'hF0) begin m_brk = 1; return; end
`ifdef PS2_BREAK_FILTER_EN
        if (m_brk) begin
            if (b == m_scan) m_scan = 8'h00;
        end else begin
            exp_q.push_back(e);
            m_scan = b;
        end
`else
        e.rel = m_brk;
        exp_q.push_back(e);
        m_scan = b;
`endif
        m_ext = 0; m_brk = 0;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (detected && frame_err) begin
                total++; bad++;
                $display("FAIL overlap: detected=1 frame_err=1 required never both");
            end else if (detected || frame_err) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_pulse: detected=%0b frame_err=%0b scanCode=%h required no pulse",
                             detected, frame_err, scanCode);
                end else begin
                    ev = exp_q.pop_front();
                    if (ev.err) begin
                        if (!frame_err) begin
                            bad++;
                            $display("FAIL event: got detected scanCode=%h required frame_err", scanCode);
                        end else
                            $display("event frame_err");
                    end else if (!detected || scanCode !== ev.code || extended !== ev.ext || released !== ev.rel) begin
                        bad++;
                        $display("FAIL event: got det=%0b code=%h ext=%0b rel=%0b required det=1 code=%h ext=%0b rel=%0b",
                                 detected, scanCode, extended, released, ev.code, ev.ext, ev.rel);
                    end else
                        $display("event detected code=%h ext=%0b rel=%0b", scanCode, extended, released);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h required=%h", name, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input bit b, input bit glitch);
        ps2_data = b;
        if (glitch) begin
            cyc(4);
            ps2_clk = 1'b0;
            cyc(FL - 1);
            ps2_clk = 1'b1;
        end
        cyc(HALF);
        ps2_clk = 1'b0;
        cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits, input int glitch_at);
        logic [10:0] fr;
        logic        par;
        par = ~(^b) ^ bad_par;
        fr  = {1'b1, par, b, 1'b0};
        if (nbits == 11) model_frame(b, !bad_par);
        for (int i = 0; i < nbits; i++) send_bit(fr[i], i == glitch_at);
        ps2_data = 1'b1;
    endtask

    task automatic settle(input string name);
        cyc(3 * HALF);
        chk({name, "_pending"}, exp_q.size(), 0);
        chk({name, "_scan"}, {24'h0, scanCode}, {24'h0, m_scan});
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] code;
        int         r;
        cyc(3);
        #1;
        chk("rst_scan", {24'h0, scanCode}, 32'h0);
        chk("rst_det", {31'h0, detected}, 32'h0);
        chk("rst_ext", {31'h0, extended}, 32'h0);
        chk("rst_rel", {31'h0, released}, 32'h0);
        chk("rst_err", {31'h0, frame_err}, 32'h0);
        cyc(1);
        rst_n = 1'b1;
        cyc(10);

        send_frame(8'h1B, 0, 11, -1);
        settle("basic");
        chk("basic_lit", {24'h0, scanCode}, 32'h1B);

        send_frame(8'hE0, 0, 11, -1);
        send_frame(8'h75, 0, 11, -1);
        settle("ext");
        chk("ext_lit_code", {24'h0, scanCode}, 32'h75);
        chk("ext_lit_flag", {31'h0, extended}, 32'h1);

        send_frame(8'h76, 1, 11, -1);
        settle("parity");
        chk("parity_lit_hold", {24'h0, scanCode}, 32'h75);

        send_frame(8'h1B, 0, 11, -1);
        send_frame(8'hF0, 0, 11, -1);
        send_frame(8'h1B, 0, 11, -1);
        settle("break");
`ifdef PS2_BREAK_FILTER_EN
        chk("break_lit", {24'h0, scanCode}, 32'h00);
`else
        chk("break_lit", {24'h0, scanCode}, 32'h1B);
        chk("break_lit_rel", {31'h0, released}, 32'h1);
`endif

        send_frame(8'h5A, 0, 5, -1);
        model_frame(8'h00, 0);
        cyc(TO + 100);
        chk("timeout_pending", exp_q.size(), 0);
        send_frame(8'h4D, 0, 11, -1);
        settle("timeout");
        chk("timeout_lit", {24'h0, scanCode}, 32'h4D);

        send_frame(8'h2C, 0, 11, 4);
        settle("glitch");
        chk("glitch_lit", {24'h0, scanCode}, 32'h2C);

        send_frame(8'h33, 0, 4, -1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_scan", {24'h0, scanCode}, 32'h0);
        chk("midrst_det", {31'h0, detected}, 32'h0);
        chk("midrst_ext", {31'h0, extended}, 32'h0);
        chk("midrst_rel", {31'h0, released}, 32'h0);
        chk("midrst_err", {31'h0, frame_err}, 32'h0);
        m_scan = 8'h00; m_ext = 0; m_brk = 0;
        cyc(3);
        rst_n = 1'b1;
        cyc(10);
        send_frame(8'h1C, 0, 11, -1);
        settle("midrst");
        chk("midrst_lit", {24'h0, scanCode}, 32'h1C);

        for (int t = 0; t < 25; t++) begin
            r = $urandom_range(0, 9);
            if (r < 2) send_frame(8'hE0, 0, 11, -1);
            else if (r < 4) send_frame(8'hF0, 0, 11, -1);
            else if (r == 4) begin
                send_frame(8'hE0, 0, 11, -1);
                send_frame(8'hF0, 0, 11, -1);
            end
            code = 8'($urandom_range(0, 255));
            while (code == 8'hE0 || code == 8'hF0) code = 8'($urandom_range(0, 255));
            if (r >= 2 && r < 4 && $urandom_range(0, 1) == 1) code = m_scan == 8'h00 ? 8'h11 : m_scan;
            send_frame(code, $urandom_range(0, 7) == 0, 11, -1);
            settle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
